// File: rtl/pll_reset_pkg.sv
// Shared types and sizing helpers for the PLL reset sequencer.
package pll_reset_pkg;

   typedef enum logic [1:0] {
      WAIT_LOCK,
      STABILIZE,
      RELEASE,
      RUN
   } state_e;

   localparam int SYNC_STAGES = 2;

   // Width of a counter that runs 0..cycles-1; never narrower than one bit.
   function automatic int cnt_w(input int cycles);
      return (cycles > 1) ? $clog2(cycles) : 1;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser with async active-low clear.
// Latency: 2 clk edges; no backpressure.
module sync_2ff
   import pll_reset_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o
);

   logic [SYNC_STAGES-1:0] sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      end
   end

   assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Lock-qualified, ordered release of NUM_STAGES active-low resets.
// Latency: bit k released 2+LOCK_STABLE_CYCLES+k*STAGE_GAP_CYCLES edges after lock is sampled; no backpressure.
module pll_reset_sequencer
   import pll_reset_pkg::*;
#(
   parameter int LOCK_STABLE_CYCLES = 1024,
   parameter int STAGE_GAP_CYCLES   = 16,
   parameter int NUM_STAGES         = 3,
   parameter int LOSS_CNT_W         = 8
) (
   input  logic                  global_clock,
   input  logic                  reset_n,
   input  logic                  locked,
   input  logic                  force_reset,
   output logic [NUM_STAGES-1:0] sys_reset_n,
   output logic                  ready,
   output logic [LOSS_CNT_W-1:0] lock_loss_count
);

   localparam int STABLE_W = cnt_w(LOCK_STABLE_CYCLES);
   localparam int GAP_W    = cnt_w(STAGE_GAP_CYCLES);
   localparam logic [STABLE_W-1:0] STABLE_LAST = STABLE_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [GAP_W-1:0]    GAP_LAST    = GAP_W'(STAGE_GAP_CYCLES - 1);

   logic                  locked_sync;
   state_e                state_q, state_d;
   logic [STABLE_W-1:0]   stable_q, stable_d;
   logic [GAP_W-1:0]      gap_q, gap_d;
   logic [NUM_STAGES-1:0] stage_q, stage_d;
   logic                  ready_q, ready_d;
   logic [LOSS_CNT_W-1:0] loss_q, loss_d;

   sync_2ff u_lock_sync (
      .clk   (global_clock),
      .rst_n (reset_n),
      .d_i   (locked),
      .q_o   (locked_sync)
   );

   always_ff @(posedge global_clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= WAIT_LOCK;
         stable_q <= '0;
         gap_q    <= '0;
         stage_q  <= '0;
         ready_q  <= 1'b0;
         loss_q   <= '0;
      end else begin
         state_q  <= state_d;
         stable_q <= stable_d;
         gap_q    <= gap_d;
         stage_q  <= stage_d;
         ready_q  <= ready_d;
         loss_q   <= loss_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      stable_d = stable_q;
      gap_d    = gap_q;
      stage_d  = stage_q;
      ready_d  = ready_q;
      loss_d   = loss_q;
      unique case (state_q)
         WAIT_LOCK: begin
            stage_d = '0;
            ready_d = 1'b0;
            if (locked_sync) begin
               state_d  = STABILIZE;
               stable_d = '0;
            end
         end
         STABILIZE: begin
            if (!locked_sync || force_reset) begin
               state_d = WAIT_LOCK;
            end else if (stable_q == STABLE_LAST) begin
               stage_d = NUM_STAGES'(1);
               gap_d   = '0;
               // A single-stage build is fully released on this same edge.
               state_d = stage_d[NUM_STAGES-1] ? RUN : RELEASE;
            end else begin
               stable_d = stable_q + STABLE_W'(1);
            end
         end
         RELEASE, RUN: begin
            // Lock loss wins over a coincident force_reset so it is still counted.
            if (!locked_sync) begin
               state_d = WAIT_LOCK;
               stage_d = '0;
               ready_d = 1'b0;
               if (loss_q != '1) begin
                  loss_d = loss_q + LOSS_CNT_W'(1);
               end
            end else if (force_reset) begin
               state_d = WAIT_LOCK;
               stage_d = '0;
               ready_d = 1'b0;
            end else if (state_q == RUN) begin
               ready_d = 1'b1;
            end else if (gap_q == GAP_LAST) begin
               stage_d = NUM_STAGES'({stage_q, 1'b1});
               gap_d   = '0;
               if (stage_d[NUM_STAGES-1]) begin
                  state_d = RUN;
               end
            end else begin
               gap_d = gap_q + GAP_W'(1);
            end
         end
         default: state_d = WAIT_LOCK;
      endcase
   end

   assign sys_reset_n     = stage_q;
   assign ready           = ready_q;
   assign lock_loss_count = loss_q;

endmodule
